board_uart_controller: RTL



---
 rtl/board_uart_pkg.sv | 28 ++
 rtl/board_uart_rx_core.sv | 101 ++++++++++
 rtl/board_uart_controller.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/board_uart_pkg.sv
// Shared types and frame constants for the board UART responder.
package board_uart_pkg;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP,
      TX_DONE
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START_CHK,
      RX_DATA,
      RX_STOP_CHK,
      RX_BREAK
   } rx_state_t;

   localparam int   DATA_BITS = 8;
   localparam logic START_LVL = 1'b0;
   localparam logic STOP_LVL  = 1'b1;
   localparam logic IDLE_LVL  = 1'b1;

   localparam int RESP_SEND = 0;
   localparam int RESP_RECV = 1;

endpackage

// File: rtl/board_uart_rx_core.sv
// Receive core: 2-flop synchronizer, 8N1 receive FSM and mid-bit sampler.
// frame_ok pulses for one cycle in the stop-bit sampling cycle of a good frame.
module board_uart_rx_core
   import board_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rxd,
   output logic [7:0] rx_byte,
   output logic       frame_ok
);

   localparam int             CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]  CNT_MAX  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]  HALF_MAX = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [2:0]     LAST_BIT = 3'(DATA_BITS - 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          prev_q, prev_d;
   rx_state_t     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= IDLE_LVL;
         sync2_q <= IDLE_LVL;
         prev_q  <= IDLE_LVL;
         state_q <= RX_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
      end
   end

   always_comb begin
      sync1_d = rxd;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      case (state_q)
         RX_IDLE: begin
            cnt_d = '0;
            if (prev_q == IDLE_LVL && sync2_q == START_LVL) state_d = RX_START_CHK;
         end
         RX_START_CHK: begin
            // Half-bit resample rejects glitches and aligns later samples to mid-bit.
            if (cnt_q == HALF_MAX) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = (sync2_q == START_LVL) ? RX_DATA : RX_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RX_DATA: begin
            if (cnt_q == CNT_MAX) begin
               cnt_d   = '0;
               shift_d = {sync2_q, shift_q[7:1]};
               if (bit_q == LAST_BIT) state_d = RX_STOP_CHK;
               else                   bit_d   = bit_q + 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RX_STOP_CHK: begin
            if (cnt_q == CNT_MAX) begin
               cnt_d   = '0;
               state_d = (sync2_q == STOP_LVL) ? RX_IDLE : RX_BREAK;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RX_BREAK: begin
            if (sync2_q == IDLE_LVL) state_d = RX_IDLE;
         end
         default: state_d = RX_IDLE;
      endcase
   end

   always_comb begin
      rx_byte  = shift_q;
      frame_ok = (state_q == RX_STOP_CHK) && (cnt_q == CNT_MAX) && (sync2_q == STOP_LVL);
   end

endmodule

// File: rtl/board_uart_controller.sv
// Board stdio UART responder: TX FSM, receive arming and delivery around the rx core.
// Optional feature: BOARD_UART_RX_HOLD_EN keeps one byte that arrived while unarmed.
module board_uart_controller
   import board_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] UART_BYTE_OUT,
   input  logic       UART_START_SEND,
   input  logic       UART_START_RECEIVE,
   output logic [7:0] UART_BYTE_IN,
   output logic [1:0] UART_RESPONSE,
   output logic       UART_TXD,
   input  logic       UART_RXD
);

   localparam int            CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

   logic          send_prev_q, send_prev_d, recv_prev_q, recv_prev_d;
   logic          send_edge, recv_edge;
   tx_state_t     tx_state_q, tx_state_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]    tx_bit_q, tx_bit_d;
   logic [7:0]    tx_shift_q, tx_shift_d;
   logic          txd_q, txd_d;
   logic [1:0]    resp_q, resp_d;
   logic [7:0]    byte_in_q, byte_in_d;
   logic          armed_q, armed_d, armed_eff;
   logic [7:0]    rx_byte;
   logic          frame_ok;
`ifdef BOARD_UART_RX_HOLD_EN
   logic [7:0]    hold_q, hold_d;
   logic          hold_full_q, hold_full_d;
`endif

   board_uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_core (
      .clk      (clk),
      .reset_n  (reset_n),
      .rxd      (UART_RXD),
      .rx_byte  (rx_byte),
      .frame_ok (frame_ok)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         send_prev_q <= 1'b0;
         recv_prev_q <= 1'b0;
         tx_state_q  <= TX_IDLE;
         tx_cnt_q    <= '0;
         tx_bit_q    <= '0;
         tx_shift_q  <= '0;
         txd_q       <= IDLE_LVL;
         resp_q      <= '0;
         byte_in_q   <= '0;
         armed_q     <= 1'b0;
`ifdef BOARD_UART_RX_HOLD_EN
         hold_q      <= '0;
         hold_full_q <= 1'b0;
`endif
      end else begin
         send_prev_q <= send_prev_d;
         recv_prev_q <= recv_prev_d;
         tx_state_q  <= tx_state_d;
         tx_cnt_q    <= tx_cnt_d;
         tx_bit_q    <= tx_bit_d;
         tx_shift_q  <= tx_shift_d;
         txd_q       <= txd_d;
         resp_q      <= resp_d;
         byte_in_q   <= byte_in_d;
         armed_q     <= armed_d;
`ifdef BOARD_UART_RX_HOLD_EN
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
`endif
      end
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      case (tx_state_q)
         TX_IDLE: begin
            tx_cnt_d = '0;
            if (send_edge) begin
               tx_shift_d = UART_BYTE_OUT;
               tx_state_d = TX_START;
            end
         end
         TX_START: begin
            if (tx_cnt_q == CNT_MAX) begin
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
               tx_state_d = TX_DATA;
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         TX_DATA: begin
            if (tx_cnt_q == CNT_MAX) begin
               tx_cnt_d = '0;
               if (tx_bit_q == LAST_BIT) tx_state_d = TX_STOP;
               else                      tx_bit_d   = tx_bit_q + 1'b1;
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         TX_STOP: begin
            if (tx_cnt_q == CNT_MAX) begin
               tx_cnt_d   = '0;
               tx_state_d = TX_DONE;
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         TX_DONE: tx_state_d = TX_IDLE;
         default: tx_state_d = TX_IDLE;
      endcase
   end

   // Line level and done pulse follow the next state so both leave flops.
   always_comb begin
      case (tx_state_d)
         TX_START: txd_d = START_LVL;
         TX_DATA:  txd_d = tx_shift_q[tx_bit_d];
         TX_STOP:  txd_d = STOP_LVL;
         default:  txd_d = IDLE_LVL;
      endcase
      resp_d[RESP_SEND] = (tx_state_d == TX_DONE);
   end

   always_comb begin
      send_prev_d       = UART_START_SEND;
      recv_prev_d       = UART_START_RECEIVE;
      send_edge         = UART_START_SEND & ~send_prev_q;
      recv_edge         = UART_START_RECEIVE & ~recv_prev_q;
      byte_in_d         = byte_in_q;
      armed_d           = armed_q;
      resp_d[RESP_RECV] = 1'b0;
`ifdef BOARD_UART_RX_HOLD_EN
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      // An arm edge with a held byte consumes it instead of arming.
      armed_eff   = armed_q | (recv_edge & ~hold_full_q);
      if (recv_edge && hold_full_q) begin
         byte_in_d         = hold_q;
         resp_d[RESP_RECV] = 1'b1;
         hold_full_d       = 1'b0;
      end else if (recv_edge) begin
         armed_d = 1'b1;
      end
      if (frame_ok) begin
         if (armed_eff) begin
            byte_in_d         = rx_byte;
            resp_d[RESP_RECV] = 1'b1;
            armed_d           = 1'b0;
         end else begin
            hold_d      = rx_byte;
            hold_full_d = 1'b1;
         end
      end
`else
      armed_eff = armed_q | recv_edge;
      if (recv_edge) armed_d = 1'b1;
      if (frame_ok && armed_eff) begin
         byte_in_d         = rx_byte;
         resp_d[RESP_RECV] = 1'b1;
         armed_d           = 1'b0;
      end
`endif
   end

   assign UART_TXD      = txd_q;
   assign UART_RESPONSE = resp_q;
   assign UART_BYTE_IN  = byte_in_q;

endmodule
